// File: rtl/vin_delta_join.sv
// Rebuilds u = (vin + delta) / 2^IB as a normalized IEEE double from a segment
// index and an in-segment offset; 3-stage pipeline with push/stop flow control.
module vin_delta_join #(
  parameter string U1_U2 = "u2"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pushin,
  input  logic [9:0]  vin,
  input  logic [63:0] delta,
  input  logic        stopin,
  output logic        stopout,
  output logic        pushout,
  output logic [63:0] u
);

  localparam int unsigned IB = (U1_U2 == "u1") ? 9 : 10;
  localparam int unsigned FB = 52 - IB;

  logic          v1_q, v1_d, s1_q, s1_d;
  logic [IB-1:0] idx1_q, idx1_d;
  logic [FB-1:0] frac1_q, frac1_d;
  logic          v2_q, v2_d, s2_q, s2_d, z2_q, z2_d;
  logic [51:0]   f2_q, f2_d;
  logic [5:0]    n2_q, n2_d;
  logic          pushout_q, pushout_d;
  logic [63:0]   u_q, u_d;

  logic [10:0]   ed, sh;
  logic [52:0]   m;
  logic [51:0]   f_cat, mant;

  assign stopout = stopin;
  assign pushout = pushout_q;
  assign u       = u_q;

  always_comb begin
    // S1: unpack delta into a truncated FB-bit fraction
    v1_d    = pushin;
    s1_d    = delta[63];
    idx1_d  = vin[IB-1:0];
    ed      = delta[62:52];
    m       = {1'b1, delta[51:0]};
    sh      = '0;
    frac1_d = '0;
    if (ed >= 11'd1023) begin
      frac1_d = '1;
    end else begin
      sh = 11'd1022 - ed;
      // top FB bits of (m >> sh) are m shifted a further 53-FB places
      if (sh < 11'(FB)) frac1_d = FB'(m >> (sh + 11'(53 - FB)));
    end

    // S2: combine index and fraction, count leading zeros
    f_cat = {idx1_q, frac1_q};
    v2_d  = v1_q;
    s2_d  = s1_q;
    f2_d  = f_cat;
    z2_d  = (f_cat == 52'd0);
    n2_d  = '0;
    for (int i = 0; i < 52; i++) begin
      if (f_cat[i]) n2_d = 6'(51 - i);
    end

    // S3: normalize and pack; hidden bit falls off the top
    pushout_d = v2_q;
    mant      = f2_q << (n2_q + 6'd1);
    u_d       = z2_q ? 64'd0 : {s2_q, 11'(11'd1022 - 11'(n2_q)), mant};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      s1_q      <= 1'b0;
      idx1_q    <= '0;
      frac1_q   <= '0;
      v2_q      <= 1'b0;
      s2_q      <= 1'b0;
      z2_q      <= 1'b0;
      f2_q      <= '0;
      n2_q      <= '0;
      pushout_q <= 1'b0;
      u_q       <= '0;
    end else if (!stopin) begin
      v1_q      <= v1_d;
      s1_q      <= s1_d;
      idx1_q    <= idx1_d;
      frac1_q   <= frac1_d;
      v2_q      <= v2_d;
      s2_q      <= s2_d;
      z2_q      <= z2_d;
      f2_q      <= f2_d;
      n2_q      <= n2_d;
      pushout_q <= pushout_d;
      u_q       <= u_d;
    end
  end

endmodule

// File: tb/tb_vin_delta_join.sv
// Directed and randomized checks of vin_delta_join in both "u2" and "u1" builds.
module tb_vin_delta_join;

  logic        clk = 1'b0;
  logic        rst_n, pushin, stopin;
  logic [9:0]  vin;
  logic [63:0] delta;
  logic        stopout2, pushout2, stopout1, pushout1;
  logic [63:0] u2, u1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vin_delta_join #(.U1_U2("u2")) dut2 (
    .clk(clk), .rst_n(rst_n), .pushin(pushin), .vin(vin), .delta(delta),
    .stopin(stopin), .stopout(stopout2), .pushout(pushout2), .u(u2));

  vin_delta_join #(.U1_U2("u1")) dut1 (
    .clk(clk), .rst_n(rst_n), .pushin(pushin), .vin(vin), .delta(delta),
    .stopin(stopin), .stopout(stopout1), .pushout(pushout1), .u(u1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one item, then idle until pushout (bounded); returns outputs and latency.
  task automatic send_wait(input logic [9:0] v, input logic [63:0] d,
                           output logic [63:0] o2, output logic [63:0] o1,
                           output int lat);
    vin = v; delta = d; pushin = 1'b1; stopin = 1'b0;
    step();
    pushin = 1'b0; vin = '0; delta = '0;
    lat = 1;
    while (!pushout2 && lat < 10) begin
      step();
      lat++;
    end
    o2 = u2; o1 = u1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pushin = 1'b1; stopin = 1'b1; vin = 10'h3ff; delta = 64'h3FE0000000000000;
    step(); step();
    total++; if (pushout2 !== 1'b0) begin bad++; $display("FAIL reset_pushout got=%b want=0", pushout2); end
    total++; if (u2 !== 64'h0) begin bad++; $display("FAIL reset_u got=%h want=0", u2); end
    total++; if (stopout2 !== 1'b1) begin bad++; $display("FAIL stopout_hi got=%b want=1", stopout2); end
    stopin = 1'b0; #1;
    total++; if (stopout2 !== 1'b0) begin bad++; $display("FAIL stopout_lo got=%b want=0", stopout2); end
    pushin = 1'b0; rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [63:0] o2, o1;
    int lat;
    send_wait(10'h300, 64'h3BF0000000000000, o2, o1, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL t1_latency got=%0d want=3", lat); end
    total++; if (o2 !== 64'h3FE8000000000000) begin bad++; $display("FAIL t1_u got=%h want=3fe8000000000000", o2); end
    send_wait(10'h001, 64'h3FE0000000000000, o2, o1, lat);
    total++; if (o2 !== 64'h3F58000000000000) begin bad++; $display("FAIL t2_u got=%h want=3f58000000000000", o2); end
    total++; if (o1 !== 64'h3F68000000000000) begin bad++; $display("FAIL t2_u1 got=%h want=3f68000000000000", o1); end
    send_wait(10'h000, 64'h0, o2, o1, lat);
    total++; if (o2 !== 64'h0) begin bad++; $display("FAIL t3_zero got=%h want=0", o2); end
    // delta=1.0 saturates the fraction: 2^-10 - 2^-52
    send_wait(10'h000, 64'h3FF0000000000000, o2, o1, lat);
    total++; if (o2 !== 64'h3F4FFFFFFFFFF800) begin bad++; $display("FAIL t3_sat got=%h want=3f4ffffffffff800", o2); end
    send_wait(10'h200, 64'h0, o2, o1, lat);
    total++; if (o1 !== 64'h0) begin bad++; $display("FAIL t4_u1_vin9 got=%h want=0", o1); end
    total++; if (o2 !== 64'h3FE0000000000000) begin bad++; $display("FAIL t4_u2_vin9 got=%h want=3fe0000000000000", o2); end
    // negative sign passes through on a non-zero result
    send_wait(10'h300, 64'hBBF0000000000000, o2, o1, lat);
    total++; if (o2 !== 64'hBFE8000000000000) begin bad++; $display("FAIL sign_u got=%h want=bfe8000000000000", o2); end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  pv [11] = '{10'h300, 10'h001, 10'h000, 10'h3ff, 10'h3ff, 0, 0, 0, 0, 0, 0};
    logic [63:0] pd [11] = '{64'h3BF0000000000000, 64'h3FE0000000000000, 64'h3FF0000000000000,
                             64'h3FE0000000000000, 64'h3FE0000000000000, 0, 0, 0, 0, 0, 0};
    logic        pp [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    logic        ps [11] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    logic [63:0] want [3] = '{64'h3FE8000000000000, 64'h3F58000000000000, 64'h3F4FFFFFFFFFF800};
    logic [63:0] got [$];
    logic [63:0] u_before;
    logic        p_before;
    for (int c = 0; c < 11; c++) begin
      vin = pv[c]; delta = pd[c]; pushin = pp[c]; stopin = ps[c];
      if (pushout2 && !stopin) got.push_back(u2);
      u_before = u2; p_before = pushout2;
      step();
      if (ps[c]) begin
        total++;
        if (u2 !== u_before || pushout2 !== p_before) begin
          bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h want=%b/%h", c, pushout2, u2, p_before, u_before);
        end
      end
    end
    pushin = 1'b0; stopin = 1'b0;
    total++; if (got.size() !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== want[i]) begin bad++; $display("FAIL b2b_item%0d got=%h want=%h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    vin = 10'h300; delta = 64'h3BF0000000000000; pushin = 1'b1; stopin = 1'b0;
    step(); step();
    pushin = 1'b0; rst_n = 1'b0;
    step();
    total++; if (pushout2 !== 1'b0 || u2 !== 64'h0) begin bad++; $display("FAIL midrst got=%b/%h want=0/0", pushout2, u2); end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (pushout2 !== 1'b0) begin bad++; $display("FAIL midrst_stale cyc=%0d got=%b want=0", c, pushout2); end
    end
  endtask

  // Forward split modelled with exact real arithmetic: delta = frac/2^42, u = {vin,frac}/2^52.
  task automatic test_random_roundtrip();
    logic [63:0] exp_q [$];
    logic [9:0]  rv;
    logic [41:0] rf;
    longint      fl;
    real         r;
    int          sent = 0, recv = 0, cyc = 0;
    bit          have = 0;
    while ((sent < 300 || exp_q.size() > 0) && cyc < 3000) begin
      if (!have && sent < 300) begin
        rv = 10'($urandom);
        rf = 42'({$urandom, $urandom});
        if ($urandom_range(0, 15) == 0) rf = '0;
        if ($urandom_range(0, 31) == 0) rv = '0;
        r = longint'(rf);
        delta = $realtobits(r / 4398046511104.0);
        vin = rv;
        fl = longint'({rv, rf});
        r = fl;
        have = 1;
      end
      pushin = have && ($urandom_range(0, 3) != 0);
      stopin = ($urandom_range(0, 3) == 0);
      if (pushout2 && !stopin) begin
        total++; recv++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_extra got=%h want=none", u2);
        end else begin
          if (u2 !== exp_q[0]) begin bad++; $display("FAIL rand_u n=%0d got=%h want=%h", recv, u2, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (pushin && !stopin) begin
        exp_q.push_back($realtobits(r / 4503599627370496.0));
        sent++; have = 0;
      end
      step();
      cyc++;
    end
    pushin = 1'b0; stopin = 1'b0;
    total++; if (recv !== 300) begin bad++; $display("FAIL rand_count got=%0d want=300", recv); end
  endtask

  initial begin
    rst_n = 1'b0; pushin = 1'b0; stopin = 1'b0; vin = '0; delta = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random_roundtrip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
